// File: rtl/sccb_target_model_if.sv
// SCCB pin bundle between a bus master (or loopback pin pair) and the target model.
// sda_i is the resolved open-drain line level seen by the target.
interface sccb_target_model_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/sccb_target_model.sv
// OV7670-style SCCB target: 256x8 register file with read-only ID registers,
// a write-notification strobe and a registered debug read port.
module sccb_target_model #(
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter logic [7:0] PID_VALUE   = 8'h76,
  parameter logic [7:0] VER_VALUE   = 8'h73
) (
  input  logic                clk,
  input  logic                reset_,
  sccb_target_model_if.slave  bus,
  output logic                reg_wr_strobe,
  output logic [7:0]          reg_wr_addr,
  output logic [7:0]          reg_wr_data,
  input  logic [7:0]          dbg_addr,
  output logic [7:0]          dbg_data,
  output logic                busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_WRITE_SUB, ST_WRITE_DATA, ST_READ, ST_IGNORE
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  scl_sync_r, sda_sync_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r, ptr_r, tx_r;
  logic        sda_oe_r, busy_r, strobe_r;
  logic [7:0]  wr_addr_r, wr_data_r, dbg_data_r;
  logic [7:0]  rf_r [256];

  logic        scl_cur_s, scl_rise_s, scl_fall_s, sda_cur_s, start_s, stop_s;
  logic        counting_s, byte_done_s, ack_clk_s, addr_match_s, ro_ptr_s;
  logic [7:0]  byte_s;
  logic        sda_oe_nxt_s, busy_nxt_s, commit_s, load_ptr_s, inc_ptr_s, load_tx_s;

  // Pin synchronizers plus one history stage; reset to the idle-high bus level.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      scl_sync_r <= 3'b111;
      sda_sync_r <= 3'b111;
    end else begin
      scl_sync_r <= {scl_sync_r[1:0], bus.scl_i};
      sda_sync_r <= {sda_sync_r[1:0], bus.sda_i};
    end
  end

  assign scl_cur_s    = scl_sync_r[1];
  assign sda_cur_s    = sda_sync_r[1];
  assign scl_rise_s   = scl_sync_r[1] & ~scl_sync_r[2];
  assign scl_fall_s   = ~scl_sync_r[1] & scl_sync_r[2];
  assign start_s      = scl_cur_s & ~sda_sync_r[1] & sda_sync_r[2];
  assign stop_s       = scl_cur_s & sda_sync_r[1] & ~sda_sync_r[2];
  assign counting_s   = (state_r == ST_ADDR) || (state_r == ST_WRITE_SUB) ||
                        (state_r == ST_WRITE_DATA) || (state_r == ST_READ);
  assign byte_done_s  = scl_rise_s && counting_s && (bit_cnt_r == 4'd7);
  assign ack_clk_s    = scl_rise_s && counting_s && (bit_cnt_r == 4'd8);
  assign byte_s       = {shift_r[6:0], sda_cur_s};
  assign addr_match_s = (shift_r[7:1] == DEVICE_ADDR);
  assign ro_ptr_s     = (ptr_r == 8'h0A) || (ptr_r == 8'h0B);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Next state: START/STOP win everywhere; byte-level moves happen on the ACK clock.
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = ST_ADDR;
    end else if (stop_s) begin
      state_nxt_s = ST_IDLE;
    end else if (ack_clk_s) begin
      case (state_r)
        ST_ADDR:      state_nxt_s = !addr_match_s ? ST_IGNORE :
                                    (shift_r[0] ? ST_READ : ST_WRITE_SUB);
        ST_WRITE_SUB: state_nxt_s = ST_WRITE_DATA;
        ST_READ:      state_nxt_s = sda_cur_s ? ST_IGNORE : ST_READ;
        default:      state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Outputs and datapath controls; SDA drive only moves on SCL falling edges.
  always_comb begin
    sda_oe_nxt_s = sda_oe_r;
    busy_nxt_s   = busy_r;
    commit_s     = 1'b0;
    load_ptr_s   = 1'b0;
    inc_ptr_s    = 1'b0;
    load_tx_s    = 1'b0;
    if (start_s || stop_s) begin
      sda_oe_nxt_s = 1'b0;
      busy_nxt_s   = start_s;
    end else begin
      if (byte_done_s) begin
        case (state_r)
          ST_WRITE_SUB:  load_ptr_s = 1'b1;
          ST_WRITE_DATA: begin
            commit_s  = !ro_ptr_s;
            inc_ptr_s = 1'b1;
          end
          default:       load_ptr_s = 1'b0;
        endcase
      end else if (ack_clk_s && (state_r == ST_READ)) begin
        inc_ptr_s = 1'b1;
      end else begin
        inc_ptr_s = 1'b0;
      end
      if (scl_fall_s) begin
        case (state_r)
          ST_ADDR:       sda_oe_nxt_s = (bit_cnt_r == 4'd8) && addr_match_s;
          ST_WRITE_SUB,
          ST_WRITE_DATA: sda_oe_nxt_s = (bit_cnt_r == 4'd8);
          ST_READ: begin
            if (bit_cnt_r == 4'd0) begin
              load_tx_s    = 1'b1;
              sda_oe_nxt_s = ~rf_r[ptr_r][7];
            end else if (bit_cnt_r == 4'd8) begin
              sda_oe_nxt_s = 1'b0;
            end else begin
              sda_oe_nxt_s = ~tx_r[3'd7 - bit_cnt_r[2:0]];
            end
          end
          default:       sda_oe_nxt_s = 1'b0;
        endcase
      end else begin
        sda_oe_nxt_s = sda_oe_r;
      end
    end
  end

  // Bit counter (0..8, 8 = ACK slot), receive shifter, pointer and read-data latch.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      ptr_r     <= 8'h00;
      tx_r      <= 8'h00;
    end else begin
      if (start_s || stop_s)
        bit_cnt_r <= 4'd0;
      else if (scl_rise_s && counting_s)
        bit_cnt_r <= (bit_cnt_r == 4'd8) ? 4'd0 : bit_cnt_r + 4'd1;
      if (scl_rise_s && counting_s && (bit_cnt_r != 4'd8))
        shift_r <= byte_s;
      if (load_ptr_s)
        ptr_r <= byte_s;
      else if (inc_ptr_s)
        ptr_r <= ptr_r + 8'd1;
      if (load_tx_s)
        tx_r <= rf_r[ptr_r];
    end
  end

  // Registered bus drive, busy flag and write notification.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      strobe_r  <= 1'b0;
      wr_addr_r <= 8'h00;
      wr_data_r <= 8'h00;
    end else begin
      sda_oe_r <= sda_oe_nxt_s;
      busy_r   <= busy_nxt_s;
      strobe_r <= commit_s;
      if (commit_s) begin
        wr_addr_r <= ptr_r;
        wr_data_r <= byte_s;
      end
    end
  end

  // Register file with its reset image, and the registered debug read port.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 256; i++)
        rf_r[i] <= (8'(i) == 8'h0A) ? PID_VALUE :
                   (8'(i) == 8'h0B) ? VER_VALUE : 8'h00;
      dbg_data_r <= 8'h00;
    end else begin
      if (commit_s)
        rf_r[ptr_r] <= byte_s;
      dbg_data_r <= rf_r[dbg_addr];
    end
  end

  assign bus.sda_oe    = sda_oe_r;
  assign busy          = busy_r;
  assign reg_wr_strobe = strobe_r;
  assign reg_wr_addr   = wr_addr_r;
  assign reg_wr_data   = wr_data_r;
  assign dbg_data      = dbg_data_r;

endmodule

// File: tb/tb_sccb_target_model.sv
// Directed bench for sccb_target_model: a bit-banged SCCB master with
// hand-computed expectations for ACKs, read bytes, strobes and debug reads.
module tb_sccb_target_model;

  logic       clk;
  logic       reset_;
  logic       m_scl, m_sda;
  logic [7:0] dbg_addr;
  logic       reg_wr_strobe, busy;
  logic [7:0] reg_wr_addr, reg_wr_data, dbg_data;

  int checks = 0;
  int errors = 0;

  int         stb_cnt = 0;
  int         oe_cnt  = 0;
  int         stb_long = 0;
  logic       stb_prev = 1'b0;
  logic [7:0] stb_addr [64];
  logic [7:0] stb_data [64];

  sccb_target_model_if bus ();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  sccb_target_model dut (
    .clk           (clk),
    .reset_        (reset_),
    .bus           (bus),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe log, strobe width and SDA-drive activity, sampled away from the active edge.
  always @(negedge clk) begin
    if (reg_wr_strobe) begin
      if (stb_cnt < 64) begin
        stb_addr[stb_cnt] = reg_wr_addr;
        stb_data[stb_cnt] = reg_wr_data;
      end
      stb_cnt = stb_cnt + 1;
      if (stb_prev) stb_long = stb_long + 1;
    end
    stb_prev = reg_wr_strobe;
    if (bus.sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    m_sda = 1'b1; cyc(10);
    m_scl = 1'b1; cyc(10);
    m_sda = 1'b0; cyc(10);
    m_scl = 1'b0;
  endtask

  task automatic stop_c();
    cyc(3);  m_sda = 1'b0;
    cyc(7);  m_scl = 1'b1;
    cyc(10); m_sda = 1'b1;
    cyc(10);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      cyc(3);  m_sda = b[i];
      cyc(7);  m_scl = 1'b1;
      cyc(10); m_scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    cyc(3); m_sda = 1'b1;
    cyc(7); m_scl = 1'b1;
    cyc(5); ack = bus.sda_i;
    cyc(5); m_scl = 1'b0;
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    cyc(2); m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      cyc(8); m_scl = 1'b1;
      cyc(5); b[i] = bus.sda_i;
      cyc(5); m_scl = 1'b0;
      cyc(2);
    end
    cyc(1); m_sda = ack_bit;
    cyc(7); m_scl = 1'b1;
    cyc(10); m_scl = 1'b0;
  endtask

  // Full write: address 0x42, sub-address, then n data bytes from d (MSB byte first).
  task automatic wr_txn(input string tag, input logic [7:0] sub, input logic [31:0] d, input int n);
    logic a;
    start_c();
    send_byte(8'h42, a); chk({tag, "_ack_addr"}, {7'd0, a}, 8'h00);
    send_byte(sub, a);   chk({tag, "_ack_sub"},  {7'd0, a}, 8'h00);
    for (int k = 0; k < n; k++) begin
      send_byte(d[31 - 8*k -: 8], a);
      chk({tag, "_ack_data"}, {7'd0, a}, 8'h00);
    end
    stop_c();
  endtask

  // Single-byte read at the current pointer, closed with a master NACK.
  task automatic rd_txn(input string tag, input logic [7:0] exp);
    logic       a;
    logic [7:0] b;
    start_c();
    send_byte(8'h43, a); chk({tag, "_ack_rd_addr"}, {7'd0, a}, 8'h00);
    recv_byte(1'b1, b);  chk({tag, "_rd_data"}, b, exp);
    stop_c();
  endtask

  task automatic dbg_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    @(negedge clk) dbg_addr = addr;
    @(negedge clk) chk(tag, dbg_data, exp);
  endtask

  initial begin
    int         snap;
    int         oe_snap;
    logic       a;
    logic [7:0] b;

    reset_   = 1'b0;
    m_scl    = 1'b1;
    m_sda    = 1'b1;
    dbg_addr = 8'h0A;
    cyc(4);
    chk("rst_sda_oe", {7'd0, bus.sda_oe}, 8'h00);
    chk("rst_strobe", {7'd0, reg_wr_strobe}, 8'h00);
    chk("rst_wr_addr", reg_wr_addr, 8'h00);
    chk("rst_wr_data", reg_wr_data, 8'h00);
    chk("rst_dbg_data", dbg_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    reset_ = 1'b1;
    cyc(2);
    chk("rst_pid_image", dbg_data, 8'h76);

    // Single register write.
    snap = stb_cnt;
    wr_txn("t1", 8'h12, 32'h8000_0000, 1);
    chk("t1_strobe_count", 8'(stb_cnt - snap), 8'd1);
    chk("t1_strobe_addr", stb_addr[snap], 8'h12);
    chk("t1_strobe_data", stb_data[snap], 8'h80);
    dbg_chk("t1_dbg", 8'h12, 8'h80);

    // Sub-address-only write, then reads continue from the stored pointer.
    wr_txn("t2_pre", 8'h3B, 32'hC300_0000, 1);
    snap = stb_cnt;
    wr_txn("t2", 8'h3A, 32'h0, 0);
    rd_txn("t2_a", 8'h00);
    rd_txn("t2_b", 8'hC3);
    chk("t2_no_strobe", 8'(stb_cnt - snap), 8'd0);

    // Multi-byte write wrapping the pointer past 0xFF.
    snap = stb_cnt;
    wr_txn("t3", 8'hFE, 32'h1122_3300, 3);
    chk("t3_strobe_count", 8'(stb_cnt - snap), 8'd3);
    chk("t3_addr0", stb_addr[snap], 8'hFE);
    chk("t3_addr1", stb_addr[snap + 1], 8'hFF);
    chk("t3_addr2", stb_addr[snap + 2], 8'h00);
    chk("t3_data2", stb_data[snap + 2], 8'h33);
    rd_txn("t3_rd01", 8'h00);
    dbg_chk("t3_dbg_ff", 8'hFF, 8'h22);
    dbg_chk("t3_dbg_00", 8'h00, 8'h33);

    // Read-only ID registers: write ignored, burst read with repeated start.
    snap = stb_cnt;
    wr_txn("t4", 8'h0A, 32'h5500_0000, 1);
    chk("t4_no_strobe", 8'(stb_cnt - snap), 8'd0);
    start_c();
    send_byte(8'h42, a); chk("t4_ack_w", {7'd0, a}, 8'h00);
    send_byte(8'h0A, a); chk("t4_ack_sub", {7'd0, a}, 8'h00);
    start_c();
    send_byte(8'h43, a); chk("t4_ack_r", {7'd0, a}, 8'h00);
    recv_byte(1'b0, b);  chk("t4_pid", b, 8'h76);
    recv_byte(1'b1, b);  chk("t4_ver", b, 8'h73);
    stop_c();
    dbg_chk("t4_dbg_0a", 8'h0A, 8'h76);

    // Wrong device ID is ignored; the next transaction is served normally.
    snap    = stb_cnt;
    oe_snap = oe_cnt;
    start_c();
    send_byte(8'h40, a); chk("t5_nack", {7'd0, a}, 8'h01);
    send_byte(8'h12, a); chk("t5_nack_data", {7'd0, a}, 8'h01);
    chk("t5_busy_hi", {7'd0, busy}, 8'h01);
    stop_c();
    chk("t5_busy_lo", {7'd0, busy}, 8'h00);
    chk("t5_no_oe", 8'(oe_cnt - oe_snap), 8'd0);
    chk("t5_no_strobe", 8'(stb_cnt - snap), 8'd0);
    wr_txn("t5_ok", 8'h50, 32'h6600_0000, 1);
    chk("t5_ok_strobe_addr", stb_addr[snap], 8'h50);
    chk("t5_ok_strobe_data", stb_data[snap], 8'h66);

    // Reset in the middle of a data byte.
    snap = stb_cnt;
    start_c();
    send_byte(8'h42, a); chk("t6_ack_addr", {7'd0, a}, 8'h00);
    send_byte(8'h20, a); chk("t6_ack_sub", {7'd0, a}, 8'h00);
    send_bits(8'h99, 4);
    cyc(3);
    reset_ = 1'b0;
    #1;
    chk("t6_rst_sda_oe", {7'd0, bus.sda_oe}, 8'h00);
    chk("t6_rst_busy", {7'd0, busy}, 8'h00);
    chk("t6_rst_wr_addr", reg_wr_addr, 8'h00);
    cyc(3);
    reset_ = 1'b1;
    cyc(2);
    chk("t6_no_strobe", 8'(stb_cnt - snap), 8'd0);
    dbg_chk("t6_rf_cleared", 8'h12, 8'h00);
    wr_txn("t6_after", 8'h20, 32'h9900_0000, 1);
    chk("t6_strobe_count", 8'(stb_cnt - snap), 8'd1);
    chk("t6_strobe_addr", stb_addr[snap], 8'h20);
    chk("t6_strobe_data", stb_data[snap], 8'h99);
    dbg_chk("t6_dbg", 8'h20, 8'h99);

    chk("strobe_single_cycle", 8'(stb_long), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
